// File: rtl/axi_slave_read.sv
// AXI4 read-channel responder (AR + R) for an SRAM-backed slave.
// Serves one INCR burst at a time; each beat is fetched from a synchronous
// single-port SRAM with 1-cycle read latency and then presented on R.
// The AR channel is held off while the write side owns the SRAM.
module axi_slave_read #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned MEM_AW = 14
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic              write_busy,
  output logic              rd_busy,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DATA  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic in_data;
  logic last_beat;

  // Size and burst type are fixed (4-byte INCR), so these inputs carry no information.
  logic unused_ar;
  assign unused_ar = ^{ARSIZE, ARBURST};

  assign in_data   = (state_q == DATA);
  assign last_beat = (cnt_q == len_q);

  // Output decode: everything is zero outside its owning state.
  always_comb begin
    ARREADY  = (state_q == IDLE) & ARESETn & ~write_busy;
    RVALID   = in_data;
    RDATA    = in_data ? rdata_q : '0;
    RID      = in_data ? id_q : '0;
    RLAST    = in_data & last_beat;
    RRESP    = 2'b00;
    rd_busy  = (state_q != IDLE);
    mem_cs   = (state_q == FETCH);
    mem_oe   = (state_q == FETCH);
    mem_addr = (state_q == FETCH) ? addr_q[MEM_AW+1:2] : '0;
  end

  // Next-state and register update logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (ARVALID && ARREADY) begin
          id_d    = ARID;
          addr_d  = ARADDR;
          len_d   = ARLEN;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        // SRAM data is valid the cycle after the chip-select cycle.
        rdata_d = mem_rdata;
        state_d = DATA;
      end
      DATA: begin
        if (RREADY) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
            addr_d  = addr_q + ADDR_W'(4);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and burst registers; async reset discards any burst in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_slave_read.sv
// Self-checking bench for axi_slave_read: SRAM model, scoreboard of expected
// R beats, directed timing scenarios and a randomized burst phase.
module tb_axi_slave_read;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int MEM_AW = 14;
  localparam int MEM_WORDS = 1 << MEM_AW;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic [ID_W-1:0]   ARID = '0;
  logic [ADDR_W-1:0] ARADDR = '0;
  logic [LEN_W-1:0]  ARLEN = '0;
  logic [2:0]        ARSIZE = 3'b010;
  logic [1:0]        ARBURST = 2'b01;
  logic              ARVALID = 1'b0;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY = 1'b1;
  logic              write_busy = 1'b0;
  logic              rd_busy;
  logic              mem_cs;
  logic              mem_oe;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;

  axi_slave_read #(
    .ID_W  (ID_W),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W),
    .MEM_AW(MEM_AW)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .ARID      (ARID),
    .ARADDR    (ARADDR),
    .ARLEN     (ARLEN),
    .ARSIZE    (ARSIZE),
    .ARBURST   (ARBURST),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RID       (RID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .write_busy(write_busy),
    .rd_busy   (rd_busy),
    .mem_cs    (mem_cs),
    .mem_oe    (mem_oe),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [ID_W-1:0]   id;
    logic              last;
  } beat_t;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  beat_t             sb[$];
  int                appear_q[$];
  logic [MEM_AW-1:0] addr_log[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_edge = 0;
  bit rr_random = 0;
  bit bp_win = 0;
  bit rand_wb = 0;
  bit prev_v = 0;
  bit prev_pop = 0;

  // Synchronous SRAM model: 1-cycle read latency.
  always @(posedge ACLK) begin
    if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr];
  end

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RREADY driver: random, a cycle 3..7 backpressure window, or held high.
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      if (rr_random) RREADY = ($urandom_range(0, 3) != 0);
      else if (bp_win) RREADY = !((cyc - hs_edge + 1) >= 3 && (cyc - hs_edge + 1) <= 7);
      else RREADY = 1'b1;
    end
  end

  // Monitor: compares every presented beat against the scoreboard head.
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        prev_v   = 0;
        prev_pop = 0;
      end else begin
        if (mem_cs && mem_oe) addr_log.push_back(mem_addr);
        if (RVALID) begin
          if (!prev_v || prev_pop) appear_q.push_back(cyc - hs_edge + 1);
          if (sb.size() == 0) begin
            chk("unexpected_beat", 64'(RVALID), 64'd0);
          end else begin
            chk("rdata", 64'(RDATA), 64'(sb[0].d));
            chk("rid", 64'(RID), 64'(sb[0].id));
            chk("rlast", 64'(RLAST), 64'(sb[0].last));
            chk("rresp", 64'(RRESP), 64'd0);
            if (RREADY) void'(sb.pop_front());
          end
          prev_pop = RREADY;
        end
        prev_v = RVALID;
      end
    end
  end

  // Reference: beat k reads word ((ARADDR/4)+k) mod 2^MEM_AW.
  task automatic push_expected(input logic [31:0] addr, input int len, input logic [7:0] id);
    beat_t b;
    for (int k = 0; k <= len; k++) begin
      b.d    = mem[((addr >> 2) + 32'(k)) % MEM_WORDS];
      b.id   = id;
      b.last = (k == len);
      sb.push_back(b);
    end
  endtask

  task automatic do_ar(input logic [31:0] addr, input int len, input logic [7:0] id);
    bit ok;
    ok = 0;
    @(posedge ACLK);
    #1;
    ARVALID = 1'b1;
    ARADDR  = addr;
    ARLEN   = LEN_W'(len);
    ARID    = id;
    for (int i = 0; i < 300; i++) begin
      @(negedge ACLK);
      if (write_busy) chk("arready_while_write_busy", 64'(ARREADY), 64'd0);
      if (ARREADY) begin
        ok = 1;
        break;
      end
      @(posedge ACLK);
      #1;
      if (rand_wb) write_busy = ($urandom_range(0, 2) == 0);
    end
    if (!ok) begin
      chk("ar_handshake_timeout", 64'd0, 64'd1);
    end else begin
      hs_edge = cyc + 1;
      push_expected(addr, len, id);
      @(posedge ACLK);
      #1;
    end
    ARVALID = 1'b0;
    ARADDR  = $urandom;
    ARID    = ID_W'($urandom);
  endtask

  task automatic wait_done(output int rel);
    bit done;
    done = 0;
    rel  = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge ACLK);
      if (sb.size() == 0 && !rd_busy) begin
        rel  = cyc - hs_edge + 1;
        done = 1;
        break;
      end
    end
    if (!done) chk("burst_completion_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_appear(input string name, input int e0, input int e1, input int e2,
                            input int e3, input int n);
    int exp_t[4];
    exp_t = '{e0, e1, e2, e3};
    chk({name, "_beat_count"}, 64'(appear_q.size()), 64'(n));
    for (int i = 0; i < n && i < appear_q.size(); i++) chk({name, "_beat_cycle"},
                                                          64'(appear_q[i]), 64'(exp_t[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int nv;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;

    // Reset values.
    #3;
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rlast", 64'(RLAST), 64'd0);
    chk("rst_rd_busy", 64'(rd_busy), 64'd0);
    chk("rst_mem_cs", 64'(mem_cs), 64'd0);
    chk("rst_rdata_rid", 64'({RDATA, RID}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("idle_arready", 64'(ARREADY), 64'd1);

    // Single beat.
    mem[16'h10] = 32'hDEADBEEF;
    appear_q.delete();
    do_ar(32'h40, 0, 8'h15);
    wait_done(rel);
    chk_appear("single", 3, 0, 0, 0, 1);

    // 4-beat burst with RREADY held high.
    for (int i = 0; i < 4; i++) mem[16'h100 + i] = 32'(i + 1);
    appear_q.delete();
    addr_log.delete();
    do_ar(32'h400, 3, 8'h21);
    wait_done(rel);
    chk_appear("burst4", 3, 6, 9, 12, 4);
    chk("burst4_arready_cycle", 64'(rel), 64'd13);
    chk("burst4_arready", 64'(ARREADY), 64'd1);
    chk("burst4_addr_count", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("burst4_mem_addr", 64'(addr_log[i]), 64'(16'h100 + i));

    // Backpressure during cycles 3..7.
    bp_win = 1;
    appear_q.delete();
    do_ar(32'h400, 3, 8'h33);
    wait_done(rel);
    chk_appear("backpressure", 3, 11, 14, 17, 4);
    bp_win = 0;

    // Write contention holds off the AR handshake.
    @(posedge ACLK);
    #1;
    write_busy = 1'b1;
    ARVALID = 1'b1;
    ARADDR  = 32'h40;
    ARLEN   = '0;
    ARID    = 8'h2A;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("wb_arready_low", 64'(ARREADY), 64'd0);
      chk("wb_rd_busy_low", 64'(rd_busy), 64'd0);
      @(posedge ACLK);
      #1;
    end
    write_busy = 1'b0;
    @(negedge ACLK);
    chk("wb_released_arready", 64'(ARREADY), 64'd1);
    hs_edge = cyc + 1;
    push_expected(32'h40, 0, 8'h2A);
    @(posedge ACLK);
    #1;
    ARVALID = 1'b0;
    chk("wb_rd_busy_after_hs", 64'(rd_busy), 64'd1);
    wait_done(rel);

    // Word-address wrap.
    mem[MEM_WORDS-1] = 32'hA5A5_0001;
    mem[0] = 32'h5A5A_0002;
    addr_log.delete();
    do_ar(32'hFFFC, 1, 8'h44);
    wait_done(rel);
    chk("wrap_addr_count", 64'(addr_log.size()), 64'd2);
    if (addr_log.size() == 2) begin
      chk("wrap_mem_addr0", 64'(addr_log[0]), 64'h3FFF);
      chk("wrap_mem_addr1", 64'(addr_log[1]), 64'h0000);
    end

    // Reset in the DATA phase of beat 2.
    appear_q.delete();
    do_ar(32'h400, 3, 8'h55);
    for (int i = 0; i < 40 && appear_q.size() < 2; i++) begin
      @(negedge ACLK);
      #1;
    end
    chk("rst_mid_reached_beat2", 64'(appear_q.size()), 64'd2);
    chk("rst_mid_rvalid_before", 64'(RVALID), 64'd1);
    ARESETn = 1'b0;
    #1;
    chk("rst_mid_rvalid", 64'(RVALID), 64'd0);
    chk("rst_mid_rlast", 64'(RLAST), 64'd0);
    chk("rst_mid_mem_cs_oe", 64'({mem_cs, mem_oe}), 64'd0);
    chk("rst_mid_rd_busy", 64'(rd_busy), 64'd0);
    chk("rst_mid_arready", 64'(ARREADY), 64'd0);
    sb.delete();
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    nv = 0;
    @(negedge ACLK);
    chk("rst_mid_arready_after", 64'(ARREADY), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (RVALID || mem_cs || rd_busy) nv++;
    end
    chk("rst_mid_no_resume", 64'(nv), 64'd0);

    // Randomized bursts with random backpressure and write-side contention.
    rr_random = 1;
    rand_wb = 1;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom;
      if (n % 5 == 0) a[15:2] = 14'h3FFF - 14'($urandom_range(0, 3));
      do_ar(a, int'($urandom_range(0, 15)), 8'($urandom));
    end
    rand_wb = 0;
    write_busy = 1'b0;
    wait_done(rel);
    rr_random = 0;
    chk("random_sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_slave_read.md
Name: axi_slave_read

Overview:
- AXI4 read-channel responder (AR + R) for an SRAM-backed slave; the other end of the CPU-side read master.
- Accepts one outstanding INCR burst at a time, fetches each beat from a synchronous single-port SRAM with 1-cycle read latency, and returns beats on R with correct RID/RLAST.
- Shares the SRAM with the slave's write-side block: it yields the AR channel while writes are active and reports its own busy status.

Parameters:
ID_W, 8, ARID/RID width (slave-side ID, master ID plus arbiter prefix)
ADDR_W, 32, AXI address width
DATA_W, 32, data width; one beat = 4 bytes
LEN_W, 4, ARLEN width (bursts of 1..16 beats)
MEM_AW, 14, SRAM word-address width

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
ARID  in  ID_W  read address ID
ARADDR  in  ADDR_W  byte start address
ARLEN  in  LEN_W  beats minus 1
ARSIZE  in  3  ignored; always treated as 3'b010
ARBURST  in  2  ignored; always treated as INCR
ARVALID  in  1  address valid
ARREADY  out  1  address accept
RID  out  ID_W  ID of the burst being returned
RDATA  out  DATA_W  beat data
RRESP  out  2  always 2'b00 (OKAY)
RLAST  out  1  final beat flag
RVALID  out  1  beat valid
RREADY  in  1  master accepts beat
write_busy  in  1  slave write side owns the SRAM
rd_busy  out  1  high whenever state != IDLE
mem_cs  out  1  SRAM chip select
mem_oe  out  1  SRAM read enable
mem_addr  out  MEM_AW  SRAM word address
mem_rdata  in  DATA_W  SRAM data; valid the cycle after mem_cs&mem_oe

Behaviour:
- States: IDLE, FETCH, WAIT, DATA. State and all registers are cleared asynchronously when ARESETn=0.
- Registers: id_q, addr_q (ADDR_W), len_q, cnt_q (LEN_W), rdata_q.
- IDLE:
  - ARREADY = ARESETn & !write_busy; all other outputs are 0.
  - On ARVALID&ARREADY: latch id_q=ARID, addr_q=ARADDR, len_q=ARLEN, cnt_q=0, then go to FETCH.
  - If write_busy and ARVALID are high together, the AR handshake is not taken; the master holds ARVALID.
- FETCH (1 cycle):
  - mem_cs=1, mem_oe=1, mem_addr=addr_q[MEM_AW+1:2].
  - Go to WAIT.
- WAIT (1 cycle):
  - mem_cs=0, mem_oe=0.
  - rdata_q <= mem_rdata at the clock edge.
  - Go to DATA.
- DATA:
  - RVALID=1, RDATA=rdata_q, RID=id_q, RRESP=0, RLAST=(cnt_q==len_q).
  - RVALID, RDATA, RID and RLAST stay stable until RREADY is high.
  - On RREADY & !RLAST: cnt_q+1, addr_q+4, go to FETCH.
  - On RREADY & RLAST: go to IDLE.
- ARREADY=0 in every state except IDLE. RVALID=0 and RLAST=0 outside DATA. RDATA=0 and RID=0 outside DATA.
- write_busy is ignored once a burst has started; the write side must check rd_busy before it takes the SRAM.
- Latency, with the AR handshake at edge 0 and RREADY held high: beat k shows RVALID from cycle 3+3k. A 4-beat burst completes with RLAST at cycle 12, and ARREADY is asserted again in cycle 13.
- Address arithmetic:
  - addr_q increments modulo 2^ADDR_W.
  - mem_addr is addr_q[MEM_AW+1:2], so it wraps from word 2^MEM_AW-1 to word 0.
  - ARADDR[1:0] is ignored.
- ARLEN=0 gives a single beat with RLAST=1 on that beat.
- Reset mid-burst (asynchronous assert):
  - RVALID, RLAST, mem_cs, mem_oe and rd_busy go to 0 immediately.
  - The burst is discarded; no beats resume after reset release.
- Reset values: ARREADY=0 while ARESETn=0. Every other output is 0.

Test Plan:
- Single beat, mem word 0x10 = 0xDEADBEEF, RREADY=1:
  - Stimulus: ARADDR=0x40, ARLEN=0, ARID=8'h15.
  - Required: at cycle 3, RVALID=1, RDATA=0xDEADBEEF, RID=8'h15, RLAST=1, RRESP=0.
- 4-beat burst, words 0x100..0x103 = 1,2,3,4, RREADY=1:
  - Stimulus: ARADDR=0x400, ARLEN=3.
  - Required: RVALID at cycles 3,6,9,12 with data 1,2,3,4; RLAST only at cycle 12; mem_addr 0x100..0x103.
- Backpressure:
  - Stimulus: same burst as above, with RREADY=0 for cycles 3-7.
  - Required: RDATA=1 and RVALID=1 held unchanged through cycle 8; the second beat appears at cycle 11.
- Write contention:
  - Stimulus: write_busy=1 while ARVALID=1 for 5 cycles, then write_busy=0.
  - Required: ARREADY=0 during those 5 cycles; handshake on the first cycle with write_busy=0; rd_busy=1 from the next cycle.
- Wrap:
  - Stimulus: ARADDR=0xFFFC, ARLEN=1, MEM_AW=14.
  - Required: mem_addr is 0x3FFF then 0x0000.
- Reset mid-burst:
  - Stimulus: ARESETn=0 during DATA of beat 2 of a 4-beat burst.
  - Required: RVALID=0 within the same cycle. After release, state=IDLE, ARREADY=1, and no further beats.
